// File: rtl/oop_dac_rx.sv
// Receiver for the out-of-plane cathode DAC serial frame (SYNC_N / CLK / DATA, MSB first).
// Optional frame timeout is enabled by defining OOP_RX_TIMEOUT_EN.
module oop_dac_rx #(
   parameter int unsigned FRAME_BITS     = 24,
   parameter int unsigned DATA_BITS      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                           clk48mhz,
   input  logic                           rstn,
   input  logic                           SER_CLK,
   input  logic                           SER_SYNC_N,
   input  logic                           SER_DATA,
   output logic [DATA_BITS-1:0]           RX_VALUE,
   output logic [FRAME_BITS-DATA_BITS-1:0] RX_CTRL,
   output logic                           RX_VALID,
   output logic                           RX_FRAME_ERR,
   output logic [15:0]                    RX_FRAME_CNT,
   output logic                           RX_BUSY
);

   localparam int unsigned CtrlBits = FRAME_BITS - DATA_BITS;
   localparam int unsigned CntW     = $clog2(FRAME_BITS + 2);
   localparam int unsigned TmoW     = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {StWaitHigh, StIdle, StShift} state_e;

   // Bit 0 is the first synchronizer stage.
   logic [2:0] clk_sync_q, clk_sync_d;
   logic [2:0] sync_sync_q, sync_sync_d;
   logic [1:0] data_sync_q, data_sync_d;

   // Edge strobes are registered once more so the output pulse lands 3 cycles after sampling.
   logic clk_rise_q, clk_rise_d;
   logic sync_rise_q, sync_rise_d;
   logic sync_fall_q, sync_fall_d;
   logic sync_lvl_q, sync_lvl_d;
   logic data_q, data_d;

   state_e                state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [TmoW-1:0]       tmo_q, tmo_d;
   logic [DATA_BITS-1:0]  value_q, value_d;
   logic [CtrlBits-1:0]   ctrl_q, ctrl_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  busy_q, busy_d;

   always_comb begin
      clk_sync_d  = {clk_sync_q[1:0], SER_CLK};
      sync_sync_d = {sync_sync_q[1:0], SER_SYNC_N};
      data_sync_d = {data_sync_q[0], SER_DATA};
      clk_rise_d  = clk_sync_q[1] & ~clk_sync_q[2];
      sync_rise_d = sync_sync_q[1] & ~sync_sync_q[2];
      sync_fall_d = ~sync_sync_q[1] & sync_sync_q[2];
      sync_lvl_d  = sync_sync_q[1];
      data_d      = data_sync_q[1];
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tmo_d     = tmo_q;
      value_d   = value_q;
      ctrl_d    = ctrl_q;
      cnt_d     = cnt_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StWaitHigh: begin
            if (sync_lvl_q) state_d = StIdle;
         end
         StIdle: begin
            if (sync_fall_q) begin
               state_d   = StShift;
               bit_cnt_d = '0;
               shift_d   = '0;
               tmo_d     = '0;
            end
         end
         StShift: begin
            // A SYNC_N rise wins over a coincident clock edge: the frame closes on bits so far.
            if (sync_rise_q) begin
               state_d = StIdle;
               if (bit_cnt_q == CntW'(FRAME_BITS)) begin
                  value_d = shift_q[DATA_BITS-1:0];
                  ctrl_d  = shift_q[FRAME_BITS-1:DATA_BITS];
                  cnt_d   = cnt_q + 16'd1;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (clk_rise_q && !sync_lvl_q) begin
               shift_d = {shift_q[FRAME_BITS-2:0], data_q};
               tmo_d   = '0;
               if (bit_cnt_q != CntW'(FRAME_BITS + 1)) bit_cnt_d = bit_cnt_q + CntW'(1);
            end
`ifdef OOP_RX_TIMEOUT_EN
            else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
               state_d = StWaitHigh;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
`else
            else begin
               tmo_d = '0;
            end
`endif
         end
         default: state_d = StWaitHigh;
      endcase
      busy_d = (state_d == StShift);
   end

   always_ff @(posedge clk48mhz) begin
      if (!rstn) begin
         clk_sync_q  <= '0;
         sync_sync_q <= '0;
         data_sync_q <= '0;
         clk_rise_q  <= 1'b0;
         sync_rise_q <= 1'b0;
         sync_fall_q <= 1'b0;
         sync_lvl_q  <= 1'b0;
         data_q      <= 1'b0;
         state_q     <= StWaitHigh;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         tmo_q       <= '0;
         value_q     <= '0;
         ctrl_q      <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         sync_sync_q <= sync_sync_d;
         data_sync_q <= data_sync_d;
         clk_rise_q  <= clk_rise_d;
         sync_rise_q <= sync_rise_d;
         sync_fall_q <= sync_fall_d;
         sync_lvl_q  <= sync_lvl_d;
         data_q      <= data_d;
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         tmo_q       <= tmo_d;
         value_q     <= value_d;
         ctrl_q      <= ctrl_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
      end
   end

   assign RX_VALUE     = value_q;
   assign RX_CTRL      = ctrl_q;
   assign RX_VALID     = valid_q;
   assign RX_FRAME_ERR = err_q;
   assign RX_FRAME_CNT = cnt_q;
   assign RX_BUSY      = busy_q;

endmodule
